// File: rtl/nor_stim_checker.sv
// rtl/nor_stim_checker.sv - clocked stimulus sequencer and truth-table checker for a 2-input gate
//
// Drives a,b through all four input combinations for PASSES sweeps, holds each
// vector SETTLE+1 cycles and samples c on the last edge of the hold against TRUTH.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             begin a run (honoured in IDLE only)
//   a, b              registered gate inputs
//   c                 gate output under test (must be settled before the sample edge)
//   busy              high while a run is in progress, including the DONE cycle
//   done              one-cycle end-of-run pulse
//   pass              run had zero mismatches; held until the next start
//   err_cnt           mismatch count, saturating at 255
//   fail_valid        at least one mismatch this run
//   fail_vec          {a,b} of the first mismatch
//   fail_mask         (NOR_STIM_MASK_EN only) per-vector mismatch flags for the run
//
// Optional feature macro: NOR_STIM_MASK_EN
module nor_stim_checker #(
    parameter int         SETTLE = 2,
    parameter logic [3:0] TRUTH  = 4'b0001,
    parameter int         PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic       fail_valid,
    output logic [1:0] fail_vec
`ifdef NOR_STIM_MASK_EN
    ,
    output logic [3:0] fail_mask
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [15:0] SETTLE_LD  = 16'(SETTLE - 1);
    localparam logic [7:0]  LAST_SWEEP = 8'(PASSES - 1);

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [7:0]  sweep;
    logic [1:0]  v;
    logic        mismatch;
    logic        last_vec;
    logic [7:0]  err_next;

    // The driven inputs double as the vector index.
    assign v        = {a, b};
    assign mismatch = (state == S_SAMPLE) && (c != TRUTH[v]);
    assign last_vec = (v == 2'd3) && (sweep == LAST_SWEEP);
    assign err_next = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_SETTLE;
            S_SETTLE: if (cnt == 16'd0) state_n = S_SAMPLE;
            S_SAMPLE: state_n = last_vec ? S_DONE : S_SETTLE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a          <= 1'b0;
            b          <= 1'b0;
            cnt        <= 16'd0;
            sweep      <= 8'd0;
            pass       <= 1'b0;
            err_cnt    <= 8'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
`ifdef NOR_STIM_MASK_EN
            fail_mask  <= 4'b0000;
`endif
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        {a, b}     <= 2'b00;
                        sweep      <= 8'd0;
                        cnt        <= SETTLE_LD;
                        pass       <= 1'b0;
                        err_cnt    <= 8'd0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 2'b00;
`ifdef NOR_STIM_MASK_EN
                        fail_mask  <= 4'b0000;
`endif
                    end
                end
                S_SETTLE: begin
                    if (cnt != 16'd0) cnt <= cnt - 16'd1;
                end
                S_SAMPLE: begin
                    err_cnt <= err_next;
                    if (mismatch) begin
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= v;
                        end
`ifdef NOR_STIM_MASK_EN
                        fail_mask[v] <= 1'b1;
`endif
                    end
                    if (last_vec) begin
                        // Uses the post-sample count so a miss on the final vector fails the run.
                        pass <= (err_next == 8'd0);
                    end else begin
                        {a, b} <= v + 2'd1;
                        if (v == 2'd3) sweep <= sweep + 8'd1;
                        cnt <= SETTLE_LD;
                    end
                end
                S_DONE: begin
                    {a, b} <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_stim_checker.sv
// tb/tb_nor_stim_checker.sv - directed self-checking bench for nor_stim_checker
module tb_nor_stim_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    int         mode = 0;
    int         sel = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       a0, b0, c0, busy0, done0, pass0, fv0;
    logic [7:0] err0;
    logic [1:0] fvec0;
    logic       a1, b1, c1, busy1, done1, pass1, fv1;
    logic [7:0] err1;
    logic [1:0] fvec1;
    logic       a2, b2, c2, busy2, done2, pass2, fv2;
    logic [7:0] err2;
    logic [1:0] fvec2;
`ifdef NOR_STIM_MASK_EN
    logic [3:0] m0, m1, m2;
`endif
    logic       done_sel;

    always #5 clk = ~clk;

    // Instance 0: NOR gate model (mode 0) or stuck-at-0 output (mode 1).
    assign c0 = (mode == 0) ? ~(a0 | b0) : 1'b0;
    assign c1 = 1'b1;
    assign c2 = a2 | b2;

    always_comb begin
        case (sel)
            0:       done_sel = done0;
            1:       done_sel = done1;
            default: done_sel = done2;
        endcase
    end

    nor_stim_checker u_def (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a0), .b(b0), .c(c0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_valid(fv0), .fail_vec(fvec0)
`ifdef NOR_STIM_MASK_EN
        , .fail_mask(m0)
`endif
    );

    nor_stim_checker #(.PASSES(3)) u_p3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_valid(fv1), .fail_vec(fvec1)
`ifdef NOR_STIM_MASK_EN
        , .fail_mask(m1)
`endif
    );

    nor_stim_checker #(.PASSES(100), .SETTLE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a2), .b(b2), .c(c2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_valid(fv2), .fail_vec(fvec2)
`ifdef NOR_STIM_MASK_EN
        , .fail_mask(m2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start on instance s; optionally pulse it again so it is sampled at edge E0+restart_at.
    // Returns the edge count at which done was first seen (-1 if never) and the number of done cycles.
    task automatic run(input int s, input int restart_at, input int limit,
                       output int lat, output int pulses);
        int n;
        sel    = s;
        lat    = -1;
        pulses = 0;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        n = 0;
        while (n < limit) begin
            start_v[s] = (n + 1 == restart_at);
            @(posedge clk);
            #1;
            n++;
            if (done_sel) begin
                pulses++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n >= lat + 16) break;
        end
        start_v[s] = 1'b0;
    endtask

    initial begin
        int lat, pulses, extra;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_ab", {a0, b0}, 0);
        check("rst_err", err0, 0);
        check("rst_pass", pass0, 0);
        check("rst_fv", {fv0, fvec0}, 0);
        rst = 1'b0;

        // Good NOR gate, defaults.
        mode = 0;
        run(0, -1, 100, lat, pulses);
        check("nor_latency", lat, 12);
        check("nor_pulses", pulses, 1);
        check("nor_pass", pass0, 1);
        check("nor_err", err0, 0);
        check("nor_fv", fv0, 0);
        check("nor_ab_idle", {a0, b0}, 0);
        check("nor_busy_idle", busy0, 0);

        // Output stuck at 0: only vector 00 mismatches.
        mode = 1;
        run(0, -1, 100, lat, pulses);
        check("st0_latency", lat, 12);
        check("st0_err", err0, 1);
        check("st0_fv", fv0, 1);
        check("st0_fvec", fvec0, 0);
        check("st0_pass", pass0, 0);
`ifdef NOR_STIM_MASK_EN
        check("st0_mask", m0, 4'b0001);
`endif

        // Output stuck at 1, three sweeps: vectors 01,10,11 miss each sweep.
        run(1, -1, 200, lat, pulses);
        check("st1_latency", lat, 36);
        check("st1_err", err1, 9);
        check("st1_fvec", fvec1, 1);
        check("st1_pass", pass1, 0);
`ifdef NOR_STIM_MASK_EN
        check("st1_mask", m1, 4'b1110);
`endif

        // OR gate against NOR table, 100 sweeps: 400 misses saturate.
        run(2, -1, 900, lat, pulses);
        check("sat_latency", lat, 800);
        check("sat_err", err2, 255);
        check("sat_fvec", fvec2, 0);
        check("sat_pass", pass2, 0);
`ifdef NOR_STIM_MASK_EN
        check("sat_mask", m2, 4'b1111);
`endif

        // Reset mid-run (stuck-at-0 so counters are non-zero before the abort).
        mode = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("abort_busy_e0", busy0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("abort_err_e4", err0, 1);
        check("abort_ab_e4", {a0, b0}, 2'b01);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_ab", {a0, b0}, 0);
        check("abort_err", err0, 0);
        check("abort_fv", {fv0, fvec0}, 0);
        check("abort_pass", pass0, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done0) extra++;
        end
        check("abort_no_done", extra, 0);

        mode = 0;
        run(0, -1, 100, lat, pulses);
        check("rerun_latency", lat, 12);
        check("rerun_pass", pass0, 1);

        // Start during a run is ignored.
        run(0, 3, 100, lat, pulses);
        check("restart_latency", lat, 12);
        check("restart_pulses", pulses, 1);
        check("restart_pass", pass0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
